// File: rtl/gate_seq_pkg.sv
// Shared types and defaults for the gate vector sequencer.
// Holds op encodings, FSM states and parameter defaults.
package gate_seq_pkg;

  localparam int HOLD_CYCLES_DEF   = 10;
  localparam int SETTLE_CYCLES_DEF = 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Expected output of the selected 2-input gate.
// Ports: op (gate select), a, b (gate inputs), exp_c (expected output).
module gate_ref_model
  import gate_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       exp_c
);

  always_comb begin
    exp_c = a & b;
    unique case (op)
      OP_AND:  exp_c = a & b;
      OP_OR:   exp_c = a | b;
      OP_NAND: exp_c = ~(a & b);
      OP_NOR:  exp_c = ~(a | b);
      OP_XOR:  exp_c = a ^ b;
      OP_XNOR: exp_c = ~(a ^ b);
      // Unused encodings fall back to AND.
      default: exp_c = a & b;
    endcase
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives the four (a,b) vectors into a gate, checks c_in.
// Ports: clk, rst_n, start, op, c_in in; a_out, b_out, busy, done, pass, err_cnt, vec_idx out.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       c_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_AT = 8'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       exp_c;

  gate_ref_model u_ref (
    .op   (op_q),
    .a    (vec_q[1]),
    .b    (vec_q[0]),
    .exp_c(exp_c)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          op_d    = op;
          vec_d   = 2'd0;
          hold_d  = 8'd0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        hold_d = hold_q + 8'd1;
        if (hold_q == SETTLE_AT && c_in != exp_c
            && err_q != 3'd4)
          err_d = err_q + 3'd1;
        if (hold_q == HOLD_LAST) begin
          hold_d = 8'd0;
          if (vec_q == 2'd3) begin
            // vec_idx returns to 0 so the gate sees 00 in DONE.
            state_d = ST_DONE;
            vec_d   = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      vec_q   <= 2'd0;
      hold_q  <= 8'd0;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_out   = vec_q[1];
  assign b_out   = vec_q[0];
  assign vec_idx = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Randomized + directed bench for gate_vector_sequencer.
// Checks against a truth-table reference model.
module tb_gate_vector_sequencer;

  localparam int H = 10;
  localparam int S = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic       c_in;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] vec_idx;

  logic       start2 = 1'b0;
  logic       c_in2;
  logic       a2, b2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] vec2;

  int gate_sel = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Truth tables indexed by {a,b}; 6 = stuck-1, 7 = stuck-0.
  function automatic logic [3:0] tt_of(input int g);
    case (g)
      0: return 4'b1000;
      1: return 4'b1110;
      2: return 4'b0111;
      3: return 4'b0001;
      4: return 4'b0110;
      5: return 4'b1001;
      6: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic gate_out(input int g,
                                    input logic a,
                                    input logic b);
    logic [3:0] t;
    t = tt_of(g);
    return t[{a, b}];
  endfunction

  always_comb c_in  = gate_out(gate_sel, a_out, b_out);
  always_comb c_in2 = a2 & b2;

  gate_vector_sequencer #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .c_in(c_in), .a_out(a_out), .b_out(b_out),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .vec_idx(vec_idx)
  );

  gate_vector_sequencer #(.HOLD_CYCLES(2), .SETTLE_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(3'd0),
    .c_in(c_in2), .a_out(a2), .b_out(b2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .vec_idx(vec2)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // One full run; expectations come from truth tables.
  task automatic run(input logic [2:0] o, input int g,
                     input bit restart, input bit opchg);
    logic [3:0] gt, et;
    bit   [3:0] mism;
    int         total, part, v;
    gate_sel = g;
    op = o;
    gt = tt_of(g);
    et = tt_of(o > 3'd5 ? 0 : int'(o));
    total = 0;
    for (int i = 0; i < 4; i++) begin
      mism[i] = (gt[i] != et[i]);
      total += int'(mism[i]);
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 4 * H; k++) begin
      v = k / H;
      part = 0;
      for (int i = 0; i < 4; i++)
        if (mism[i] && (i * H + S < k)) part++;
      chk("vec_idx", 8'(vec_idx), 8'(v));
      chk("a_out", 8'(a_out), 8'(v / 2));
      chk("b_out", 8'(b_out), 8'(v % 2));
      chk("busy", 8'(busy), 8'd1);
      chk("done_run", 8'(done), 8'd0);
      chk("err_run", 8'(err_cnt), 8'(part));
      if (restart && k == 5) start = 1'b1;
      if (restart && k == 6) start = 1'b0;
      if (opchg && k == 20) op = 3'($urandom_range(7, 0));
      @(negedge clk);
    end
    chk("done", 8'(done), 8'd1);
    chk("busy_done", 8'(busy), 8'd0);
    chk("err_done", 8'(err_cnt), 8'(total));
    chk("pass_done", 8'(pass), 8'(total == 0));
    chk("ab_done", 8'({a_out, b_out}), 8'd0);
    @(negedge clk);
    chk("done_off", 8'(done), 8'd0);
    chk("busy_idle", 8'(busy), 8'd0);
    chk("err_hold", 8'(err_cnt), 8'(total));
    chk("pass_hold", 8'(pass), 8'(total == 0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_pass", 8'(pass), 8'd0);
    chk("rst_err", 8'(err_cnt), 8'd0);
    chk("rst_vec", 8'(vec_idx), 8'd0);
    rst_n = 1'b1;

    run(3'b000, 0, 1'b0, 1'b0);
    run(3'b100, 0, 1'b0, 1'b0);
    run(3'b010, 6, 1'b0, 1'b0);
    run(3'b011, 7, 1'b0, 1'b0);
    run(3'b001, 3, 1'b1, 1'b1);
    run(3'b111, 0, 1'b0, 1'b0);
    for (int r = 0; r < 10; r++)
      run(3'($urandom_range(7, 0)),
          int'($urandom_range(7, 0)),
          1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)));

    // Reset mid-run: no done pulse may follow.
    gate_sel = 4;
    op = 3'b000;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_busy", 8'(busy), 8'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_busy", 8'(busy), 8'd0);
    chk("mr_done", 8'(done), 8'd0);
    chk("mr_ab", 8'({a_out, b_out}), 8'd0);
    chk("mr_err", 8'(err_cnt), 8'd0);
    chk("mr_pass", 8'(pass), 8'd0);
    chk("mr_vec", 8'(vec_idx), 8'd0);
    for (int i = 0; i < 4 * H + 5; i++) begin
      @(negedge clk);
      chk("mr_nodone", 8'({busy, done}), 8'd0);
    end

    // Reset wins over start on the same edge.
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("rst_prio", 8'(busy), 8'd0);
    rst_n = 1'b1;
    start = 1'b0;

    // Back-to-back runs: RUN 8, DONE 1, IDLE 1.
    @(negedge clk) start2 = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      chk("b2b_done", 8'(done2),
          8'(i >= 9 && (i - 9) % 10 == 0));
      if (done2) begin
        chk("b2b_pass", 8'(pass2), 8'd1);
        chk("b2b_err", 8'(err2), 8'd0);
      end
    end
    start2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
